mdu_arbiter: RTL and testbench

MDU_ARBITER -- requirements
Module: mdu_arbiter

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_arbiter_rr_arb2.sv | 39 +++
 rtl/mdu_arbiter.sv | 125 ++++++++++++
 tb/tb_mdu_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide-unit front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mdu_pkg;

   // Operation codes understood by the attached multiplier.
   typedef enum logic [2:0] {
      MULT = 3'b000
   } mdu_op_e;

   // One bit is enough to name either of the two requesters.
   typedef logic req_id_t;

   // Default multiplier pipeline depth in cycles.
   localparam int DEFAULT_MUL_LATENCY = 2;

   // One slot of the tag pipeline that mirrors the multiplier pipeline.
   typedef struct packed {
      logic    vld;
      req_id_t id;
   } tag_t;

endpackage

// File: rtl/mdu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-winner pointer.
// Latency: grant is combinational in the same cycle as the requests.
// Backpressure: pointer only advances when the caller reports a completed handshake.
module rr_arb2
   import mdu_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       gnt_vld,
   output req_id_t    gnt_id
);

   // Id that won the most recent handshake; reset to 1 so requester 0 wins the first tie.
   req_id_t last_q;

   // Lone requester always wins; on a tie the one that did not win last time goes.
   always_comb begin
      gnt_vld = |req;
      gnt_id  = 1'b0;
      case (req)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~last_q;
         default: gnt_id = 1'b0;
      endcase
   end

   // Remember the winner only when its operands were actually taken.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else if (advance) begin
         last_q <= gnt_id;
      end
   end

endmodule

// File: rtl/mdu_arbiter.sv
// Shares one fixed-latency multiplier between two requesters and routes results back by tag.
// Latency: result appears exactly MUL_LATENCY cycles after the operand handshake.
// Backpressure: one handshake per cycle on the granted port; responses cannot be stalled.
module mdu_arbiter
   import mdu_pkg::*;
#(
   parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,

   input  logic        req0_vld,
   output logic        req0_rdy,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_vld,
   output logic        req1_rdy,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,

   output logic        rsp0_vld,
   output logic [31:0] rsp0_res,
   output logic        rsp1_vld,
   output logic [31:0] rsp1_res,

   output logic [31:0] mul_srcA,
   output logic [31:0] mul_srcB,
   output logic        mul_src_vld,
   output logic [2:0]  mul_op,
   output logic        mul_clear,
   input  logic [31:0] mul_res,
   input  logic        mul_res_vld,

   output logic        busy,
   output logic        tag_err
);

   logic    gnt_vld;
   req_id_t gnt_id;
   logic    issue_en;
   logic    hs;
   tag_t    tag_q [MUL_LATENCY];
   tag_t    retire;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .reset_n (reset_n),
      .req     ({req1_vld, req0_vld}),
      .advance (hs),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   // Nothing may be accepted while held in reset or while a flush is in progress;
   // gating on reset_n keeps every output quiet while the reset is asserted.
   assign issue_en  = reset_n & ~clear;
   assign hs        = gnt_vld & issue_en;

   assign req0_rdy  = issue_en & gnt_vld & (gnt_id == 1'b0);
   assign req1_rdy  = issue_en & gnt_vld & (gnt_id == 1'b1);

   assign mul_op    = MULT;
   assign mul_clear = clear & reset_n;

   // Steer the winner's operands to the multiplier; drive zeros when nothing issues.
   always_comb begin
      mul_src_vld = hs;
      mul_srcA    = '0;
      mul_srcB    = '0;
      if (hs) begin
         mul_srcA = gnt_id ? req1_a : req0_a;
         mul_srcB = gnt_id ? req1_b : req0_b;
      end
   end

   // Tag pipeline tracks which requester owns each multiplier stage; a flush drops everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MUL_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < MUL_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0].vld <= hs;
         tag_q[0].id  <= gnt_id;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign retire = tag_q[MUL_LATENCY-1];

   // Responses follow the tag, not mul_res_vld, so a misbehaving multiplier
   // cannot route a result to the wrong requester.
   always_comb begin
      rsp0_vld = retire.vld & ~clear & (retire.id == 1'b0);
      rsp1_vld = retire.vld & ~clear & (retire.id == 1'b1);
      rsp0_res = rsp0_vld ? mul_res : '0;
      rsp1_res = rsp1_vld ? mul_res : '0;
   end

   // Sticky flag for a multiplier whose valid disagrees with the expected retire slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_err <= 1'b0;
      end else if (retire.vld != mul_res_vld) begin
         tag_err <= 1'b1;
      end
   end

   // Busy whenever any stage still holds a live operation.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
         busy = busy | tag_q[i].vld;
      end
   end

endmodule

// File: tb/tb_mdu_arbiter.sv
// Bench for mdu_arbiter with a behavioural multiplier and a response scoreboard.
// Latency: checks responses exactly MUL_LATENCY cycles after each handshake.
// Backpressure: models round-robin grant and flush behaviour independently of the DUT.
module tb_mdu_arbiter;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clear;
   logic        req0_vld, req1_vld;
   logic        req0_rdy, req1_rdy;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_vld, rsp1_vld;
   logic [31:0] rsp0_res, rsp1_res;
   logic [31:0] mul_srcA, mul_srcB;
   logic        mul_src_vld;
   logic [2:0]  mul_op;
   logic        mul_clear;
   logic [31:0] mul_res;
   logic        mul_res_vld;
   logic        busy;
   logic        tag_err;

   always #5 clk = ~clk;

   mdu_arbiter #(.MUL_LATENCY(L)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (clear),
      .req0_vld    (req0_vld),
      .req0_rdy    (req0_rdy),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_vld    (req1_vld),
      .req1_rdy    (req1_rdy),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .rsp0_vld    (rsp0_vld),
      .rsp0_res    (rsp0_res),
      .rsp1_vld    (rsp1_vld),
      .rsp1_res    (rsp1_res),
      .mul_srcA    (mul_srcA),
      .mul_srcB    (mul_srcB),
      .mul_src_vld (mul_src_vld),
      .mul_op      (mul_op),
      .mul_clear   (mul_clear),
      .mul_res     (mul_res),
      .mul_res_vld (mul_res_vld),
      .busy        (busy),
      .tag_err     (tag_err)
   );

   // Behavioural multiplier; 'late' delays only the valid by one extra cycle.
   logic        late;
   logic        pv [0:2];
   logic [31:0] pr [0:2];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            pv[i] <= 1'b0;
            pr[i] <= '0;
         end
      end else begin
         pv[0] <= mul_src_vld & ~mul_clear;
         pr[0] <= mul_srcA * mul_srcB;
         pv[1] <= pv[0] & ~mul_clear;
         pr[1] <= pr[0];
         pv[2] <= pv[1] & ~mul_clear;
         pr[2] <= pr[1];
      end
   end

   assign mul_res_vld = late ? pv[2] : pv[L-1];
   assign mul_res     = pr[L-1];

   typedef struct {
      int          due;
      bit          id;
      logic [31:0] prod;
   } sb_t;

   sb_t q[$];
   int  cyc      = 0;
   int  n_checks = 0;
   int  n_fail   = 0;
   bit  mdl_last = 1'b1;
   bit  exp_err  = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
      end
   endtask

   // Called at posedge+1 after inputs are driven; checks at the following negedge.
   task automatic step();
      bit          ret_vld;
      bit          ret_id;
      logic [31:0] ret_prod;
      bit          ehs;
      bit          eid;
      bit          busy_e;
      bit          mism;
      @(negedge clk);
      if (!reset_n) begin
         q.delete();
         mdl_last = 1'b1;
         exp_err  = 1'b0;
      end
      ret_vld  = 1'b0;
      ret_id   = 1'b0;
      ret_prod = '0;
      if (q.size() != 0 && q[0].due == cyc) begin
         ret_vld  = 1'b1;
         ret_id   = q[0].id;
         ret_prod = q[0].prod;
      end
      busy_e = (q.size() != 0);
      mism   = reset_n && (ret_vld != mul_res_vld);

      eid = (req0_vld && req1_vld) ? ~mdl_last : req1_vld;
      ehs = reset_n && !clear && (req0_vld || req1_vld);

      check_val("req0_rdy", req0_rdy, ehs && !eid);
      check_val("req1_rdy", req1_rdy, ehs && eid);
      check_val("mul_src_vld", mul_src_vld, ehs);
      check_val("mul_srcA", mul_srcA, ehs ? (eid ? req1_a : req0_a) : 32'd0);
      check_val("mul_srcB", mul_srcB, ehs ? (eid ? req1_b : req0_b) : 32'd0);
      check_val("mul_clear", mul_clear, clear && reset_n);
      check_val("mul_op", mul_op, 32'd0);
      check_val("busy", busy, busy_e);
      check_val("tag_err", tag_err, exp_err);
      check_val("rsp0_vld", rsp0_vld, ret_vld && !clear && !ret_id);
      check_val("rsp1_vld", rsp1_vld, ret_vld && !clear && ret_id);
      check_val("rsp0_res", rsp0_res, (ret_vld && !clear && !ret_id) ? ret_prod : 32'd0);
      check_val("rsp1_res", rsp1_res, (ret_vld && !clear && ret_id) ? ret_prod : 32'd0);

      if (ret_vld) void'(q.pop_front());
      if (clear) q.delete();
      if (ehs) begin
         q.push_back('{cyc + L, eid, eid ? req1_a * req1_b : req0_a * req0_b});
         mdl_last = eid;
      end
      if (mism) exp_err = 1'b1;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                        input bit v1, input logic [31:0] a1, input logic [31:0] b1);
      req0_vld = v0; req0_a = a0; req0_b = b0;
      req1_vld = v1; req1_a = a1; req1_b = b1;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0);
      clear = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0);
      clear   = 1'b0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      clear   = 1'b0;
      late    = 1'b0;
      drive(1, 32'd5, 32'd6, 1, 32'd9, 32'd9);
      @(posedge clk);
      #1;
      // Requests present during reset must not be accepted.
      step();
      step();
      reset_n = 1'b1;
      idle(1);

      // Single request from port 0.
      drive(1, 32'd3, 32'd7, 0, 0, 0);
      step();
      idle(4);

      // Contention from a fresh pointer alternates 0,1,0,1.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'd10 + i, 32'd3, 1, 32'd20 + i, 32'd5);
         step();
      end
      idle(4);

      // Truncation of the product to 32 bits.
      drive(0, 0, 0, 1, 32'hFFFF_FFFF, 32'd2);
      step();
      idle(3);

      // Flush one cycle after an issue.
      drive(1, 32'd4, 32'd4, 0, 0, 0);
      step();
      drive(0, 0, 0, 1, 32'd8, 32'd8);
      clear = 1'b1;
      step();
      idle(4);

      // Reset one cycle after an issue, then a lone req1.
      drive(1, 32'd11, 32'd12, 0, 0, 0);
      step();
      do_reset();
      drive(0, 0, 0, 1, 32'd6, 32'd7);
      step();
      idle(4);

      // Random back-to-back traffic with sparse flushes.
      for (int i = 0; i < 60; i++) begin
         drive($urandom_range(0, 1), $urandom, $urandom,
               $urandom_range(0, 1), $urandom, $urandom);
         clear = ($urandom_range(0, 9) == 0);
         step();
      end
      idle(4);

      // Multiplier valid arrives one cycle late.
      late = 1'b1;
      drive(1, 32'd2, 32'd9, 0, 0, 0);
      step();
      idle(5);
      late = 1'b0;
      do_reset();
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
